opto_tooth_decoder: RTL

Front-end for the scan-motor loop. Conditions the raw opto-switch input from the code wheel, rejects glitches, and timestamps every tooth edge. Locks onto the index gap (one long tooth period per revolution) and publishes tooth index, zero pulse, per-tooth and per-revolution periods, and stall/sync status. The motor speed controller and the angle/ranging logic downstream consume these outputs instead of the raw opto line.

---
 rtl/opto_tooth_decoder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/opto_tooth_decoder.sv
// Code-wheel decoder: synchronise and deglitch the opto line, time each tooth, and lock onto the index gap.
// Raw rise to o_tooth_pulse is 3 + GLITCH_CYC cycles; free-running with no backpressure, and every output is registered.
module opto_tooth_decoder #(
  parameter int TOOTH_NUM  = 39,
  parameter int GLITCH_CYC = 8,
  parameter int STALL_CYC  = 50_000_000
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_cal_mode,
  input  logic        i_opto_switch,
  output logic        o_opto_filt,
  output logic        o_tooth_pulse,
  output logic [7:0]  o_tooth_idx,
  output logic        o_zero_pulse,
  output logic [25:0] o_tooth_period,
  output logic [29:0] o_rev_period,
  output logic        o_rev_valid,
  output logic        o_sync_ok,
  output logic        o_sync_err,
  output logic        o_stall
);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [7:0]  GLITCH_LAST = 8'(GLITCH_CYC - 1);
  localparam logic [7:0]  IDX_LAST    = 8'(TOOTH_NUM - 1);
  localparam logic [25:0] STALL_MAX   = 26'(STALL_CYC);
  localparam logic [29:0] REV_MAX     = '1;

  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic        filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [7:0]  flt_cnt_q, flt_cnt_d;
  logic [25:0] per_cnt_q, per_cnt_d, prev_per_q, prev_per_d;
  logic        prev_vld_q, prev_vld_d;
  logic [29:0] rev_cnt_q, rev_cnt_d;
  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        tooth_pulse_q, tooth_pulse_d, zero_pulse_q, zero_pulse_d;
  logic [25:0] tooth_period_q, tooth_period_d;
  logic [29:0] rev_period_q, rev_period_d;
  logic        rev_valid_q, rev_valid_d;
  logic        sync_ok_q, sync_ok_d, sync_err_q, sync_err_d, stall_q, stall_d;

  logic        edge_acc, gap;
  logic [27:0] cur_x2, prev_x3;

  always_comb begin
    sync1_d        = i_opto_switch;
    sync2_d        = sync1_q;
    filt_d         = filt_q;
    filt_prev_d    = filt_q;
    flt_cnt_d      = '0;
    per_cnt_d      = (per_cnt_q == STALL_MAX) ? per_cnt_q : per_cnt_q + 26'd1;
    prev_per_d     = prev_per_q;
    prev_vld_d     = prev_vld_q;
    rev_cnt_d      = (rev_cnt_q == REV_MAX) ? rev_cnt_q : rev_cnt_q + 30'd1;
    state_d        = state_q;
    idx_d          = idx_q;
    tooth_pulse_d  = 1'b0;
    zero_pulse_d   = 1'b0;
    tooth_period_d = tooth_period_q;
    rev_period_d   = rev_period_q;
    rev_valid_d    = 1'b0;
    sync_err_d     = 1'b0;
    stall_d        = stall_q;

    if (sync2_q != filt_q) begin
      if (flt_cnt_q == GLITCH_LAST) filt_d = ~filt_q;
      else                          flt_cnt_d = flt_cnt_q + 8'd1;
    end

    // Gap when the current tooth is at least 1.5x the previous one.
    edge_acc = filt_q & ~filt_prev_q;
    cur_x2   = {1'b0, per_cnt_q, 1'b0};
    prev_x3  = {2'b00, prev_per_q} + {1'b0, prev_per_q, 1'b0};
    gap      = prev_vld_q && (cur_x2 >= prev_x3);

    if (edge_acc) begin
      tooth_pulse_d  = 1'b1;
      tooth_period_d = per_cnt_q;
      prev_per_d     = per_cnt_q;
      prev_vld_d     = 1'b1;
      per_cnt_d      = 26'd1;
      stall_d        = 1'b0;
      if (gap) begin
        rev_cnt_d = 30'd1;
        if (state_q != SEARCH) begin
          rev_valid_d  = 1'b1;
          rev_period_d = rev_cnt_q;
        end
      end
      case (state_q)
        SEARCH: begin
          idx_d = '0;
          if (gap) begin
            state_d      = VERIFY;
            zero_pulse_d = 1'b1;
          end
        end
        VERIFY: begin
          if (gap) begin
            idx_d        = '0;
            zero_pulse_d = 1'b1;
            if (idx_q == IDX_LAST) state_d = LOCKED;
          end else if (idx_q == IDX_LAST) begin
            state_d = SEARCH;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        LOCKED: begin
          if (idx_q == IDX_LAST && gap) begin
            idx_d        = '0;
            zero_pulse_d = 1'b1;
          end else if (idx_q == IDX_LAST || gap) begin
            state_d    = SEARCH;
            idx_d      = '0;
            sync_err_d = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        default: begin
          state_d = SEARCH;
          idx_d   = '0;
        end
      endcase
    end else if (per_cnt_d == STALL_MAX) begin
      stall_d    = 1'b1;
      prev_vld_d = 1'b0;
      state_d    = SEARCH;
      idx_d      = '0;
    end

    sync_ok_d = (state_d == LOCKED);

    if (i_cal_mode) begin
      sync1_d        = 1'b1;
      sync2_d        = 1'b1;
      filt_d         = 1'b1;
      filt_prev_d    = 1'b1;
      flt_cnt_d      = '0;
      per_cnt_d      = '0;
      prev_per_d     = '0;
      prev_vld_d     = 1'b0;
      rev_cnt_d      = '0;
      state_d        = SEARCH;
      idx_d          = '0;
      tooth_pulse_d  = 1'b0;
      zero_pulse_d   = 1'b0;
      tooth_period_d = '0;
      rev_period_d   = '0;
      rev_valid_d    = 1'b0;
      sync_ok_d      = 1'b0;
      sync_err_d     = 1'b0;
      stall_d        = 1'b0;
    end
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      filt_q         <= 1'b1;
      filt_prev_q    <= 1'b1;
      flt_cnt_q      <= '0;
      per_cnt_q      <= '0;
      prev_per_q     <= '0;
      prev_vld_q     <= 1'b0;
      rev_cnt_q      <= '0;
      state_q        <= SEARCH;
      idx_q          <= '0;
      tooth_pulse_q  <= 1'b0;
      zero_pulse_q   <= 1'b0;
      tooth_period_q <= '0;
      rev_period_q   <= '0;
      rev_valid_q    <= 1'b0;
      sync_ok_q      <= 1'b0;
      sync_err_q     <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      filt_q         <= filt_d;
      filt_prev_q    <= filt_prev_d;
      flt_cnt_q      <= flt_cnt_d;
      per_cnt_q      <= per_cnt_d;
      prev_per_q     <= prev_per_d;
      prev_vld_q     <= prev_vld_d;
      rev_cnt_q      <= rev_cnt_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      tooth_pulse_q  <= tooth_pulse_d;
      zero_pulse_q   <= zero_pulse_d;
      tooth_period_q <= tooth_period_d;
      rev_period_q   <= rev_period_d;
      rev_valid_q    <= rev_valid_d;
      sync_ok_q      <= sync_ok_d;
      sync_err_q     <= sync_err_d;
      stall_q        <= stall_d;
    end
  end

  assign o_opto_filt    = filt_q;
  assign o_tooth_pulse  = tooth_pulse_q;
  assign o_tooth_idx    = idx_q;
  assign o_zero_pulse   = zero_pulse_q;
  assign o_tooth_period = tooth_period_q;
  assign o_rev_period   = rev_period_q;
  assign o_rev_valid    = rev_valid_q;
  assign o_sync_ok      = sync_ok_q;
  assign o_sync_err     = sync_err_q;
  assign o_stall        = stall_q;

endmodule
